// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-port bundle shared by the pixel requesters, the clear engine
// and the display write strobe.
//   slave  : arbiter side (takes requests, drives grants, status and write port)
//   master : producer/display side (drives requests, observes grants and writes)
interface fb_write_arbiter_if;
  logic       clear_req;
  logic [8:0] clear_color;
  logic       clear_busy;
  logic       clear_done;

  logic       req0_valid;
  logic [5:0] req0_x;
  logic [5:0] req0_y;
  logic [8:0] req0_color;
  logic       req0_ready;

  logic       req1_valid;
  logic [5:0] req1_x;
  logic [5:0] req1_y;
  logic [8:0] req1_color;
  logic       req1_ready;

  logic       write_en;
  logic [5:0] write_x;
  logic [5:0] write_y;
  logic [8:0] write_color;

  modport slave (
    input  clear_req, clear_color,
    input  req0_valid, req0_x, req0_y, req0_color,
    input  req1_valid, req1_x, req1_y, req1_color,
    output clear_busy, clear_done, req0_ready, req1_ready,
    output write_en, write_x, write_y, write_color
  );

  modport master (
    output clear_req, clear_color,
    output req0_valid, req0_x, req0_y, req0_color,
    output req1_valid, req1_x, req1_y, req1_color,
    input  clear_busy, clear_done, req0_ready, req1_ready,
    input  write_en, write_x, write_y, write_color
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Arbiter for the 64x64 LED-matrix framebuffer write port.
// Two pixel requesters are granted round-robin; a full-screen clear engine takes
// exclusive ownership while it runs. Every write strobe is spaced by at least GAP
// cycles via a down-counter that gates issue in both states.
// Ports:
//   clk_in : system clock
//   reset  : synchronous, active-high reset
//   bus    : fb_write_arbiter_if.slave (requests, grants, clear control, write port)
module fb_write_arbiter #(
  parameter int unsigned GAP = 1  // minimum cycles between write strobes, 1..16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  fb_write_arbiter_if.slave    bus
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [3:0] GapLoad = 4'(GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       last_grant_q, last_grant_d;  // index of the most recent winner
  logic [5:0] px_x_q, px_x_d;
  logic [5:0] px_y_q, px_y_d;
  logic [8:0] clr_color_q, clr_color_d;
  logic       write_en_q, write_en_d;
  logic [5:0] write_x_q, write_x_d;
  logic [5:0] write_y_q, write_y_d;
  logic [8:0] write_color_q, write_color_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic issue;
  logic grant_ok;
  logic ready0;
  logic ready1;

  assign issue    = (gap_cnt_q == 4'd0);
  assign grant_ok = !reset && (state_q == StIdle) && issue && !bus.clear_req;

  // On a tie the requester that did not win last time is granted.
  assign ready0 = grant_ok && bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign ready1 = grant_ok && bus.req1_valid && (!bus.req0_valid || !last_grant_q);

  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = issue ? 4'd0 : gap_cnt_q - 4'd1;
    last_grant_d  = last_grant_q;
    px_x_d        = px_x_q;
    px_y_d        = px_y_q;
    clr_color_d   = clr_color_q;
    write_en_d    = 1'b0;
    write_x_d     = write_x_q;
    write_y_d     = write_y_q;
    write_color_d = write_color_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          // Entry edge only latches; first clear write comes at the next issue slot.
          state_d     = StClear;
          clr_color_d = bus.clear_color;
          px_x_d      = 6'd0;
          px_y_d      = 6'd0;
          busy_d      = 1'b1;
        end else if (ready0) begin
          write_en_d    = 1'b1;
          write_x_d     = bus.req0_x;
          write_y_d     = bus.req0_y;
          write_color_d = bus.req0_color;
          gap_cnt_d     = GapLoad;
          last_grant_d  = 1'b0;
        end else if (ready1) begin
          write_en_d    = 1'b1;
          write_x_d     = bus.req1_x;
          write_y_d     = bus.req1_y;
          write_color_d = bus.req1_color;
          gap_cnt_d     = GapLoad;
          last_grant_d  = 1'b1;
        end
      end
      StClear: begin
        if (issue) begin
          write_en_d    = 1'b1;
          write_x_d     = px_x_q;
          write_y_d     = px_y_q;
          write_color_d = clr_color_q;
          gap_cnt_d     = GapLoad;
          // 6-bit counters wrap on their own, leaving both at 0 after (63,63).
          px_x_d        = px_x_q + 6'd1;
          if (px_x_q == 6'd63) begin
            px_y_d = px_y_q + 6'd1;
            if (px_y_q == 6'd63) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= StIdle;
      gap_cnt_q     <= 4'd0;
      last_grant_q  <= 1'b1;
      px_x_q        <= 6'd0;
      px_y_q        <= 6'd0;
      clr_color_q   <= 9'd0;
      write_en_q    <= 1'b0;
      write_x_q     <= 6'd0;
      write_y_q     <= 6'd0;
      write_color_q <= 9'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      last_grant_q  <= last_grant_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      clr_color_q   <= clr_color_d;
      write_en_q    <= write_en_d;
      write_x_q     <= write_x_d;
      write_y_q     <= write_y_d;
      write_color_q <= write_color_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.write_en    = write_en_q;
  assign bus.write_x     = write_x_q;
  assign bus.write_y     = write_y_q;
  assign bus.write_color = write_color_q;
  assign bus.clear_busy  = busy_q;
  assign bus.clear_done  = done_q;

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the LED-matrix framebuffer write port (`write_en`/`write_x`/`write_y`/`write_color`, 64x64 pixels, 9-bit RGB 3:3:3) between two pixel requesters and a built-in full-screen clear engine. It sits between the pixel producers (physics renderer, overlay/test pattern) and the `display` block. It enforces a minimum spacing between write strobes, grants the two requesters round-robin, and gives the clear engine exclusive ownership while it runs.

## Interface
Parameters:
- `GAP`, default 1: minimum cycles between consecutive `write_en` pulses; legal range 1..16.

Ports:
- `clk_in`  in  1  system clock.
- `reset`  in  1  reset; synchronous, active-high.
- `clear_req`  in  1  single-cycle request to fill the whole screen with `clear_color`.
- `clear_color`  in  9  fill colour, sampled on the cycle `clear_req` is accepted.
- `clear_busy`  out  1  clear engine owns the port.
- `clear_done`  out  1  one-cycle pulse, coincident with the last clear write.
- `req0_valid`, `req1_valid`  in  1  requester has a pixel.
- `req0_x`, `req0_y`, `req1_x`, `req1_y`  in  6  pixel coordinates.
- `req0_color`, `req1_color`  in  9  pixel colour.
- `req0_ready`, `req1_ready`  out  1  combinational grant. A transfer occurs on a cycle where valid and ready are both high.
- `write_en`  out  1  one-cycle write strobe to `display`.
- `write_x`, `write_y`  out  6  write coordinates, registered.
- `write_color`  out  9  write colour, registered.

## Operation
- States are IDLE and CLEAR. A down-counter `gap_cnt` (4 bits) gates every issue, in either state.
- **Issue slot:** `gap_cnt == 0`. On each issue edge, `write_en` goes to 1 and `gap_cnt` is loaded with `GAP-1`. Otherwise `gap_cnt` decrements, saturating at 0, and `write_en` goes to 0.
- **IDLE, grant rules:**
  - No grant while `clear_req` is high. The clear request wins over simultaneous pixel requests.
  - Otherwise, in an issue slot, the grant goes to the single valid requester.
  - If both requesters are valid, the grant goes to the requester that did not win the last grant. The last-grant bit resets to 1, so req0 wins the first tie.
  - `reqN_ready = IDLE && issue slot && !clear_req && grant==N`. Ready may depend on valid; valid must not depend on ready.
  - A requester must hold its payload stable while `valid && !ready`.
- **IDLE, transfer:** the accepted x/y/colour are registered onto `write_*` with `write_en=1` at the same edge. The last-grant bit updates only on an actual transfer.
- **IDLE to CLEAR:** on `clear_req` high in IDLE:
  - latch `clear_color`;
  - set the pixel counters to x=0, y=0;
  - set `clear_busy` to 1 at that edge;
  - no write is issued at that edge.
- **CLEAR:**
  - Each issue slot writes (x, y, latched colour).
  - Raster order: x increments first; when x=63 it wraps to 0 and y increments.
  - Both `reqN_ready` are held at 0 for the whole clear.
  - A `clear_req` arriving during CLEAR is ignored (not queued).
- **CLEAR to IDLE:** at the edge issuing pixel (63,63):
  - `write_en` goes to 1 and `clear_done` goes to 1;
  - `clear_busy` goes to 0;
  - the state returns to IDLE.
  - Requesters may be granted from the next issue slot onward.
- **Holding:** `write_x`, `write_y` and `write_color` keep their last value when `write_en` is 0.
- **Reset, including mid-clear:**
  - State goes to IDLE, `gap_cnt`=0, last-grant=1, pixel counters=0.
  - All outputs go to 0: `write_en`, `write_x`, `write_y`, `write_color`, `clear_busy`, `clear_done`.
  - An interrupted clear is abandoned: no `clear_done`, no further writes.
  - Ready outputs are 0 while `reset` is high.

## Timing
- Requester latency: `write_en` is high in the cycle after the valid&&ready cycle, with the accepted payload.
- Throughput: at most one write per `GAP` cycles. With `GAP=1`, writes can occur every cycle.
- Clear sequence, with `clear_req` accepted at edge E:
  - first clear write is issued at edge E+1, if `gap_cnt` is already 0 (otherwise at the first issue slot after E);
  - the 4096 writes end with the last at edge E+1+4095·`GAP`, in the steady case.
- Clear-to-requester handover: the requester's first write follows the last clear write by `GAP` cycles.

## Test plan
- **Reset values:** reset held 2 cycles → all outputs 0, both ready 0. After release, req0 valid at (5,7,9'h1C0) → req0_ready=1 that cycle; next cycle `write_en`=1, `write_x`=5, `write_y`=7, `write_color`=9'h1C0.
- **Round-robin:** `GAP=1`, both requesters valid continuously → grants alternate req0, req1, req0, ... and `write_en` is high every cycle. Dropping req1 → req0 is granted every cycle.
- **Spacing:** `GAP=16`, req0 always valid → `write_en` pulses are exactly 16 cycles apart. Ready is low for 15 of every 16 cycles.
- **Full clear:** `GAP=1`, `clear_req` with colour 9'h007 while req0 and req1 are both valid:
  - no ready during the clear;
  - exactly 4096 writes in raster order, all 9'h007;
  - `clear_done` coincides with the (63,63) write;
  - req0 is granted in the following cycle.
- **Ignored request:** a second `clear_req` mid-clear → no restart. Total write count stays 4096 and the latched colour is unchanged.
- **Reset mid-clear:** reset asserted after the 100th clear write → no further writes, `clear_done` never pulses, `clear_busy`=0, and requesters are serviced normally after release.
